pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Parameter W, 16, datapath width of PC, instruction and offset.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; begin fetching from current PC.
REQ-006 halt  in  1  stop sequencing at next instruction acceptance.
REQ-007 imem_req  out  1  instruction-memory read request.
REQ-008 imem_addr  out  W  fetch address; equals pc while imem_req=1.
REQ-009 imem_ack  in  1  memory returns imem_data this cycle.
REQ-010 imem_data  in  W  fetched instruction word.
REQ-011 instr  out  W  registered instruction to decode.
REQ-012 instr_valid  out  1  instr holds an unconsumed instruction.
REQ-013 instr_ready  in  1  decode accepts instr this cycle.
REQ-014 jmp  in  1  absolute redirect; sampled at acceptance.
REQ-015 jmp_target  in  W  absolute target.
REQ-016 br_taken  in  1  relative branch; sampled at acceptance.
REQ-017 br_offset  in  W  two's-complement branch offset.
REQ-018 pc  out  W  address of current or in-flight instruction.
REQ-019 busy  out  1  high in any state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, HOLD, HALTED.
REQ-021 IDLE: outputs quiet; start=1 -> FETCH next cycle; halt ignored.
REQ-022 FETCH: imem_req=1, imem_addr=pc; stays until imem_ack=1; on ack, instr<=imem_data, instr_valid<=1, -> HOLD.
REQ-023 HOLD: instr_valid=1, imem_req=0; acceptance = instr_valid & instr_ready.
REQ-024 On acceptance, pc SHALL update: jmp=1 -> jmp_target; else br_taken=1 -> pc+br_offset; else pc+1.
REQ-025 Priority SHALL be jmp > br_taken > sequential; jmp, br_taken and halt ignored outside acceptance cycle.
REQ-026 Additions SHALL be modulo 2^W (16'hFFFF+1 -> 16'h0000; negative offsets wrap likewise), no carry out.
REQ-027 On acceptance, instr_valid<=0; halt=0 -> FETCH; halt=1 -> HALTED (pc still updated).
REQ-028 HALTED: imem_req=0, instr_valid=0, busy=1; exit only via reset.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 Minimum issue interval: ack in first FETCH cycle + ready in first HOLD cycle = one instruction per 2 cycles.
REQ-031 imem_data SHALL be sampled only when state=FETCH and imem_ack=1; ack in other states ignored.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, busy=0, independent of clk.
REQ-033 Reset mid-fetch or mid-HOLD SHALL discard in-flight instruction; no acceptance or PC update for it.
REQ-034 Deassertion SHALL leave block in IDLE until next start pulse.

Structure
REQ-035 Shared package SHALL hold W, RESET_PC default and state encoding enum (IDLE=0, FETCH=1, HOLD=2, HALTED=3).
REQ-036 One combinational sub-module pc_add16 (a+b mod 2^16) SHALL compute next PC; one instance, operand b muxed between 16'h0001 and br_offset.
REQ-037 All outputs SHALL be registered or decoded from state register only; no input-to-output combinational path.

Verification
REQ-038 Reset, start, ack=1 and ready=1 every cycle, imem_data=16'h1234 -> imem_addr 0,1,2 on alternate cycles; instr=16'h1234.
REQ-039 pc=16'h0010 at acceptance with br_taken=1, br_offset=16'hFFFC -> next imem_addr=16'h000C.
REQ-040 jmp=1, jmp_target=16'h0200 and br_taken=1 together -> next imem_addr=16'h0200.
REQ-041 pc=16'hFFFF sequential -> next imem_addr=16'h0000; ack delayed 3 cycles -> imem_req held, imem_addr stable 16'h0000 all 4 cycles.
REQ-042 halt=1 at acceptance of pc=16'h0005 -> HALTED, pc=16'h0006, imem_req stays 0; later start pulse has no effect.
REQ-043 rst_n low during HOLD with instr_valid=1 -> instr_valid, imem_req, busy 0 before next clk edge; pc=RESET_PC.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// pc_sequencer_pkg : shared widths, reset PC and FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

  localparam int unsigned   SEQ_W        = 16;
  localparam logic [15:0]   SEQ_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_add16.sv
// ============================================================================
// pc_add16 : combinational a + b modulo 2^16 (carry out discarded)
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  assign sum = a + b;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : fetch/hold program-counter sequencer with jump and branch
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned       W        = SEQ_W,
  parameter logic [W-1:0]      RESET_PC = SEQ_RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         halt,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W-1:0] imem_data,
  output logic [W-1:0] instr,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         jmp,
  input  logic [W-1:0] jmp_target,
  input  logic         br_taken,
  input  logic [W-1:0] br_offset,
  output logic [W-1:0] pc,
  output logic         busy
);

  state_t       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;

  logic         accept;
  logic [W-1:0] add_b;
  logic [W-1:0] pc_sum;

  // Single adder serves both sequential (+1) and relative-branch updates.
  assign add_b = br_taken ? br_offset : W'(1);

  pc_add16 u_pc_add16 (
    .a   (pc_q),
    .b   (add_b),
    .sum (pc_sum)
  );

  assign accept = (state_q == HOLD) && instr_valid_q && instr_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d       = imem_data;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          instr_valid_d = 1'b0;
          pc_d          = jmp ? jmp_target : pc_sum;
          state_d       = halt ? HALTED : FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Outputs come straight from flops or a decode of the state register.
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign busy        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : directed self-checking bench for pc_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        jmp;
  logic [15:0] jmp_target;
  logic        br_taken;
  logic [15:0] br_offset;
  logic [15:0] pc;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(.W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .pc          (pc),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000;
    instr_ready = 1'b0; jmp = 1'b0; jmp_target = 16'h0000; br_taken = 1'b0; br_offset = 16'h0000;

    // Reset state
    #12;
    chk("rst_req",   imem_req,    1'b0);
    chk("rst_busy",  busy,        1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_pc",    pc,          16'h0000);
    chk("rst_instr", instr,       16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_req", imem_req, 1'b0);

    // Back-to-back streaming: one instruction every two cycles
    imem_ack = 1'b1; instr_ready = 1'b1; imem_data = 16'h1234; start = 1'b1;
    tick(); start = 1'b0;
    chk("s0_req",  imem_req,  1'b1);
    chk("s0_addr", imem_addr, 16'h0000);
    chk("s0_busy", busy,      1'b1);
    tick();
    chk("s0_hold_req", imem_req,    1'b0);
    chk("s0_valid",    instr_valid, 1'b1);
    chk("s0_instr",    instr,       16'h1234);
    tick();
    chk("s1_req",  imem_req,  1'b1);
    chk("s1_addr", imem_addr, 16'h0001);
    tick();
    chk("s1_valid", instr_valid, 1'b1);
    tick();
    chk("s2_req",  imem_req,  1'b1);
    chk("s2_addr", imem_addr, 16'h0002);

    // Negative branch offset: jump to 0x10, then branch by -4
    tick();
    jmp = 1'b1; jmp_target = 16'h0010;
    tick(); jmp = 1'b0;
    chk("j10_addr", imem_addr, 16'h0010);
    tick();
    br_taken = 1'b1; br_offset = 16'hFFFC;
    tick(); br_taken = 1'b0;
    chk("br_neg_addr", imem_addr, 16'h000C);
    chk("br_neg_req",  imem_req,  1'b1);

    // Jump wins over a simultaneous branch
    tick();
    jmp = 1'b1; jmp_target = 16'h0200; br_taken = 1'b1; br_offset = 16'h0050;
    tick(); jmp = 1'b0; br_taken = 1'b0;
    chk("prio_addr", imem_addr, 16'h0200);

    // Wrap from 0xFFFF, then a fetch stalled three cycles on ack
    tick();
    jmp = 1'b1; jmp_target = 16'hFFFF;
    tick(); jmp = 1'b0;
    chk("ffff_addr", imem_addr, 16'hFFFF);
    tick();
    imem_ack = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wait_req",  imem_req,  1'b1);
      chk("wait_addr", imem_addr, 16'h0000);
      if (i < 3) tick();
    end
    imem_ack = 1'b1; imem_data = 16'hBEEF; instr_ready = 1'b0;
    tick();
    chk("wait_valid", instr_valid, 1'b1);
    chk("wait_instr", instr,       16'hBEEF);

    // Ack and new data during HOLD are ignored; ready low holds the instruction
    imem_data = 16'h5678;
    tick();
    chk("hold_instr", instr,       16'hBEEF);
    chk("hold_valid", instr_valid, 1'b1);
    chk("hold_req",   imem_req,    1'b0);
    chk("hold_pc",    pc,          16'h0000);

    // Halt on acceptance of pc=5
    instr_ready = 1'b1; jmp = 1'b1; jmp_target = 16'h0005;
    tick(); jmp = 1'b0;
    chk("h5_addr", imem_addr, 16'h0005);
    tick();
    halt = 1'b1;
    tick(); halt = 1'b0;
    chk("halted_req",   imem_req,    1'b0);
    chk("halted_valid", instr_valid, 1'b0);
    chk("halted_busy",  busy,        1'b1);
    chk("halted_pc",    pc,          16'h0006);
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("halted_start_req",  imem_req, 1'b0);
    chk("halted_start_busy", busy,     1'b1);
    chk("halted_start_pc",   pc,       16'h0006);

    // Asynchronous reset while an instruction sits in HOLD
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; instr_ready = 1'b0; imem_data = 16'hA5A5; start = 1'b1;
    tick(); start = 1'b0;
    chk("r_fetch_req", imem_req, 1'b1);
    tick();
    chk("r_hold_valid", instr_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", instr_valid, 1'b0);
    chk("async_req",   imem_req,    1'b0);
    chk("async_busy",  busy,        1'b0);
    chk("async_pc",    pc,          16'h0000);
    chk("async_instr", instr,       16'h0000);
    @(negedge clk);
    rst_n = 1'b1; instr_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_req",  imem_req, 1'b0);
    chk("post_rst_busy", busy,     1'b0);
    chk("post_rst_pc",   pc,       16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
